// File: rtl/instr_fetch_aligner_pkg.sv
// Shared types and helpers for the instruction fetch aligner.
// The aligner turns 32-bit aligned fetches into a stream of 16/32-bit instructions.
package instr_fetch_aligner_pkg;

    localparam int HW_SLOTS = 3;
    localparam int BUF_W    = HW_SLOTS * 16;

    typedef logic [15:0] hw_t;

    // A halfword starts a compressed instruction unless its low two bits are 2'b11.
    function automatic logic is_compressed(input hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_fetch_aligner_hw_buffer.sv
// Three-slot halfword shift buffer: consumes from slot0, appends behind the survivors.
// Slots at or above the count are always kept at zero.
module instr_fetch_aligner_hw_buffer
    import instr_fetch_aligner_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic [1:0] i_consume,
    input  logic [1:0] i_append_n,
    input  hw_t        i_append_hw0,
    input  hw_t        i_append_hw1,
    output hw_t        o_hw0,
    output hw_t        o_hw1,
    output logic [1:0] o_count
);

    logic [HW_SLOTS-1:0][15:0] r_slots;
    logic [HW_SLOTS-1:0][15:0] w_slots_next;
    logic [1:0]                r_count;
    logic [1:0]                w_cnt_kept;
    logic [1:0]                w_count_next;
    logic [31:0]               w_ins;

    // Shift out consumed halfwords, then drop the appended ones in right behind the survivors.
    always_comb begin
        w_cnt_kept = r_count - i_consume;
        if (i_append_n == 2'd2) begin
            w_ins = {i_append_hw1, i_append_hw0};
        end else if (i_append_n == 2'd1) begin
            w_ins = {16'h0000, i_append_hw0};
        end else begin
            w_ins = 32'h0000_0000;
        end
        w_slots_next = (r_slots >> {i_consume, 4'b0000}) | (BUF_W'(w_ins) << {w_cnt_kept, 4'b0000});
        w_count_next = w_cnt_kept + i_append_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slots <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_slots <= '0;
            r_count <= 2'd0;
        end else begin
            r_slots <= w_slots_next;
            r_count <= w_count_next;
        end
    end

    assign o_hw0   = r_slots[0];
    assign o_hw1   = r_slots[1];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_aligner.sv
// Instruction fetch aligner: fetches aligned words, emits one 16/32-bit instruction per handshake
// with its PC, handling straddling instructions and branch/trap redirects.
module instr_fetch_aligner
    import instr_fetch_aligner_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
)(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_gnt_i,
    input  logic        fetch_rvalid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    hw_t         w_hw0;
    hw_t         w_hw1;
    hw_t         w_app_hw0;
    hw_t         w_app_hw1;
    logic [1:0]  w_count;
    logic [1:0]  w_consume;
    logic [1:0]  w_append_n;
    logic [1:0]  w_cnt_fire;
    logic [2:0]  w_cnt_next;
    logic        w_hw0_c;
    logic        w_fire;
    logic        w_accept;
    logic [31:0] w_redirect_pc;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_started;
    logic        r_outstanding;
    logic        r_drop;
    logic        r_skip_lo;

    instr_fetch_aligner_hw_buffer u_buffer (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_flush      (redirect_i),
        .i_consume    (w_consume),
        .i_append_n   (w_append_n),
        .i_append_hw0 (w_app_hw0),
        .i_append_hw1 (w_app_hw1),
        .o_hw0        (w_hw0),
        .o_hw1        (w_hw1),
        .o_count      (w_count)
    );

    // Output view of the buffer head, handshake decode and fetch request gating.
    always_comb begin
        w_hw0_c          = is_compressed(w_hw0);
        out_valid_o      = (w_count >= 2'd2) || ((w_count == 2'd1) && w_hw0_c);
        out_compressed_o = w_hw0_c;
        out_pc_o         = r_pc;
        fetch_addr_o     = r_addr;
        w_redirect_pc    = redirect_pc_i & 32'hFFFF_FFFE;
        if (w_hw0_c) begin
            out_instr_o = {16'h0000, w_hw0};
        end else begin
            out_instr_o = {w_hw1, w_hw0};
        end
        w_fire = out_valid_o && out_ready_i;
        if (!w_fire) begin
            w_consume = 2'd0;
        end else if (w_hw0_c) begin
            w_consume = 2'd1;
        end else begin
            w_consume = 2'd2;
        end
        w_accept = fetch_rvalid_i && !r_drop && !redirect_i;
        if (!w_accept) begin
            w_append_n = 2'd0;
            w_app_hw0  = 16'h0000;
            w_app_hw1  = 16'h0000;
        end else if (r_skip_lo) begin
            w_append_n = 2'd1;
            w_app_hw0  = fetch_rdata_i[31:16];
            w_app_hw1  = 16'h0000;
        end else begin
            w_append_n = 2'd2;
            w_app_hw0  = fetch_rdata_i[15:0];
            w_app_hw1  = fetch_rdata_i[31:16];
        end
        // Gate on the occupancy after both fire and append so a response can never overflow.
        w_cnt_fire  = w_count - w_consume;
        w_cnt_next  = {1'b0, w_cnt_fire} + {1'b0, w_append_n};
        fetch_req_o = r_started && !redirect_i && (!r_outstanding || fetch_rvalid_i)
                      && (w_cnt_next <= 3'd1);
    end

    // PC, fetch address and response bookkeeping; a redirect overrides everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc          <= BOOT_ADDR;
            r_addr        <= {BOOT_ADDR[31:2], 2'b00};
            r_started     <= 1'b0;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_skip_lo     <= BOOT_ADDR[1];
        end else begin
            r_started <= 1'b1;
            if (redirect_i) begin
                r_pc          <= w_redirect_pc;
                r_addr        <= {w_redirect_pc[31:2], 2'b00};
                r_outstanding <= r_outstanding && !fetch_rvalid_i;
                r_drop        <= r_outstanding && !fetch_rvalid_i;
                r_skip_lo     <= w_redirect_pc[1];
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + (w_hw0_c ? 32'd2 : 32'd4);
                end
                if (fetch_req_o && fetch_gnt_i) begin
                    r_addr <= r_addr + 32'd4;
                end
                r_outstanding <= (fetch_req_o && fetch_gnt_i) || (r_outstanding && !fetch_rvalid_i);
                if (fetch_rvalid_i) begin
                    r_drop <= 1'b0;
                end
                if (w_accept) begin
                    r_skip_lo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Bench for instr_fetch_aligner: directed scenarios plus randomized traffic, every emitted
// instruction checked against a program-order walk of the bench's own memory image.
module tb_instr_fetch_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i = 1'b0;
    logic        fetch_rvalid_i = 1'b0;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;

    instr_fetch_aligner dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .fetch_req_o      (fetch_req_o),
        .fetch_addr_o     (fetch_addr_o),
        .fetch_gnt_i      (fetch_gnt_i),
        .fetch_rvalid_i   (fetch_rvalid_i),
        .fetch_rdata_i    (fetch_rdata_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] mem [0:63];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          fires = 0;
    int unsigned ready_pct = 100;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic        redir_pend = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] last_instr = 32'h0;
    logic [31:0] last_pc = 32'h0;
    logic        last_valid = 1'b0;
    logic        last_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    task automatic fill_compressed();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            w[1:0]   = 2'($urandom_range(0, 2));
            w[17:16] = 2'($urandom_range(0, 2));
            mem[i] = w;
        end
    endtask

    // One clock cycle: drive inputs and memory response, then observe and score the handshakes.
    task automatic cycle();
        logic [15:0] lo;
        logic [31:0] e_instr;
        logic        e_c;
        @(negedge clk_i);
        out_ready_i   = ($urandom_range(0, 99) < ready_pct);
        fetch_gnt_i   = ($urandom_range(0, 99) < gnt_pct);
        redirect_i    = redir_pend;
        redirect_pc_i = redir_pc;
        redir_pend    = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            fetch_rvalid_i = 1'b1;
            fetch_rdata_i  = mem[pend_q[0].addr[7:2]];
            void'(pend_q.pop_front());
        end else begin
            fetch_rvalid_i = 1'b0;
            fetch_rdata_i  = $urandom;
        end
        #1;
        last_valid = out_valid_o;
        last_req   = fetch_req_o;
        check("addr_align", {30'h0, fetch_addr_o[1:0]}, 32'h0);
        if (out_valid_o && out_ready_i) begin
            lo = hw_at(exp_pc);
            if (lo[1:0] != 2'b11) begin
                e_instr = {16'h0000, lo};
                e_c     = 1'b1;
            end else begin
                e_instr = {hw_at(exp_pc + 32'd2), lo};
                e_c     = 1'b0;
            end
            check("instr", out_instr_o, e_instr);
            check("pc", out_pc_o, exp_pc);
            check("compressed", {31'h0, out_compressed_o}, {31'h0, e_c});
            exp_pc     = exp_pc + (e_c ? 32'd2 : 32'd4);
            last_instr = out_instr_o;
            last_pc    = out_pc_o;
            fires++;
        end
        if (redirect_i) exp_pc = redirect_pc_i & 32'hFFFF_FFFE;
        if (fetch_req_o && fetch_gnt_i) begin
            check("one_outstanding", pend_q.size(), 32'd0);
            pend_q.push_back('{addr: fetch_addr_o, due: cyc + int'($urandom_range(lat_min, lat_max))});
            gnt_log.push_back(fetch_addr_o);
        end
        cyc++;
    endtask

    task automatic run_until(input int target, input int budget);
        int b;
        b = budget;
        while (fires < target && b > 0) begin
            cycle();
            b--;
        end
        check("fire_timeout", {31'h0, fires >= target}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        fetch_gnt_i = 1'b0;
        fetch_rvalid_i = 1'b0;
        redirect_i = 1'b0;
        out_ready_i = 1'b0;
        pend_q.delete();
        exp_pc = 32'h0;
        #1;
        check("rst_valid", {31'h0, out_valid_o}, 32'd0);
        check("rst_req", {31'h0, fetch_req_o}, 32'd0);
        check("rst_addr", fetch_addr_o, 32'h0);
        check("rst_pc", out_pc_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        int gl;
        int f0;
        int b;

        // Single full instruction from word 0.
        fill_random();
        mem[0] = 32'h00A0_0093;
        do_reset();
        run_until(fires + 1, 20);
        check("t1_instr", last_instr, 32'h00A0_0093);
        check("t1_pc", last_pc, 32'h0);

        // Two compressed instructions packed in one word.
        mem[0] = 32'h0001_4501;
        do_reset();
        run_until(fires + 2, 20);
        check("t2_instr", last_instr, 32'h0000_0001);
        check("t2_pc", last_pc, 32'h2);

        // Straddling full instruction waits for the next word, then reset mid-straddle.
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h0000_0050;
        lat_min = 3; lat_max = 3;
        do_reset();
        run_until(fires + 1, 30);
        check("t3_first", last_instr, 32'h0000_4501);
        cycle();
        check("t3_wait", {31'h0, last_valid}, 32'd0);
        #2;
        rst_i = 1'b1;
        fetch_rvalid_i = 1'b0;
        fetch_gnt_i = 1'b0;
        redirect_i = 1'b0;
        #1;
        check("t6_valid", {31'h0, out_valid_o}, 32'd0);
        check("t6_req", {31'h0, fetch_req_o}, 32'd0);
        check("t6_addr", fetch_addr_o, 32'h0);
        check("t6_pc", out_pc_o, 32'h0);
        pend_q.delete();
        exp_pc = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        gl = gnt_log.size();
        run_until(fires + 2, 40);
        check("t6_refetch", (gnt_log.size() > gl) ? gnt_log[gl] : 32'hDEAD_BEEF, 32'h0);
        check("t3_straddle", last_instr, 32'h0050_0093);
        check("t3_pc", last_pc, 32'h2);

        // Consumer stall: buffer fills, fetch stops, nothing is lost afterwards.
        fill_compressed();
        lat_min = 1; lat_max = 1;
        ready_pct = 0;
        do_reset();
        f0 = fires;
        repeat (10) cycle();
        check("t4_no_fire", fires - f0, 32'd0);
        check("t4_req_stall", {31'h0, last_req}, 32'd0);
        check("t4_valid_held", {31'h0, last_valid}, 32'd1);
        ready_pct = 100;
        run_until(fires + 8, 60);

        // Redirect with a request outstanding: stale word dropped, refetch from 0x104.
        fill_random();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h4501_4501;
        lat_min = 3; lat_max = 3;
        do_reset();
        gl = gnt_log.size();
        b = 10;
        while (gnt_log.size() == gl && b > 0) begin
            cycle();
            b--;
        end
        redir_pend = 1'b1;
        redir_pc = 32'h0000_0106;
        gl = gnt_log.size();
        run_until(fires + 1, 40);
        check("t5_addr", (gnt_log.size() > gl) ? gnt_log[gl] : 32'hDEAD_BEEF, 32'h104);
        check("t5_pc", last_pc, 32'h106);
        check("t5_instr", last_instr, 32'h0000_4501);

        // PC wrap from the top of the address space back to zero.
        mem[63] = 32'h4501_0001;
        mem[0]  = 32'h0001_0001;
        lat_min = 1; lat_max = 1;
        do_reset();
        redir_pend = 1'b1;
        redir_pc = 32'hFFFF_FFFE;
        run_until(fires + 1, 30);
        check("wrap_top", last_pc, 32'hFFFF_FFFE);
        run_until(fires + 1, 30);
        check("wrap_zero", last_pc, 32'h0);

        // Random traffic: latency, grants, back-pressure and redirects.
        fill_random();
        lat_min = 1; lat_max = 4;
        gnt_pct = 60;
        ready_pct = 70;
        do_reset();
        f0 = fires;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                redir_pend = 1'b1;
                redir_pc = $urandom_range(0, 511);
            end
            cycle();
        end
        check("rand_progress", {31'h0, (fires - f0) > 50}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
